// File: rtl/oversampled_serial_tx_pkg.sv
// Shared constants, state encoding and sample expansion for the 4x-oversampled serial link.
package oversampled_serial_tx_pkg;

    localparam int unsigned OSR             = 4;
    localparam int unsigned SAMPLES_PER_CLK = 8;
    localparam int unsigned BITS_PER_CLK    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Each bit becomes OSR identical samples; bit0 occupies the earliest samples.
    function automatic logic [SAMPLES_PER_CLK-1:0] expand_pair(input logic [BITS_PER_CLK-1:0] pair);
        return {{OSR{pair[1]}}, {OSR{pair[0]}}};
    endfunction

endpackage

// File: rtl/oversampled_serial_tx_if.sv
// Word stream in, oversampled sample window and status out.
interface oversampled_serial_tx_if #(
    parameter int unsigned DATA_W = 8
);
    import oversampled_serial_tx_pkg::*;

    logic [DATA_W-1:0]          s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic [SAMPLES_PER_CLK-1:0] sample_window;
    logic                       busy;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  sample_window,
        input  busy
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output sample_window,
        output busy
    );

endinterface

// File: rtl/oversampled_serial_tx_phase_shifter.sv
// Delays the sample stream by 0-3 samples using the current and previous unshifted windows.
module tx_phase_shifter
    import oversampled_serial_tx_pkg::*;
(
    input  logic                       clk,
    input  logic                       areset,
    input  logic [1:0]                 i_phase,
    input  logic [SAMPLES_PER_CLK-1:0] i_cur_win,
    output logic [SAMPLES_PER_CLK-1:0] o_win_c
);

    localparam int unsigned EXT_W = 2 * SAMPLES_PER_CLK;
    localparam int unsigned SH_W  = $clog2(SAMPLES_PER_CLK + 1);

    logic [SAMPLES_PER_CLK-1:0] r_prev;
    logic [EXT_W-1:0]           w_ext;
    logic [SH_W-1:0]            w_sh;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_cur_win;
        end
    end

    // Output bit i takes ext[i + 8 - phase]: older samples slide in from the previous window.
    assign w_ext   = {i_cur_win, r_prev};
    assign w_sh    = SH_W'(SAMPLES_PER_CLK) - SH_W'(i_phase);
    assign o_win_c = SAMPLES_PER_CLK'(w_ext >> w_sh);

endmodule

// File: rtl/oversampled_serial_tx.sv
// Serialises words LSB first at 2 bits/clock into 4x-oversampled 8-sample windows.
// Optional TX_PHASE_SHIFT_EN adds a 2-bit phase input delaying the stream by 0-3 samples.
module oversampled_serial_tx
    import oversampled_serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter logic [1:0]  IDLE_PAIR = 2'b01
) (
    input  logic clk,
    input  logic areset,
`ifdef TX_PHASE_SHIFT_EN
    input  logic [1:0] phase,
`endif
    oversampled_serial_tx_if.slave bus
);

    localparam int unsigned PAIRS = DATA_W / BITS_PER_CLK;
    localparam int unsigned CNT_W = $clog2(PAIRS + 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [DATA_W-1:0]          r_shreg;
    logic [DATA_W-1:0]          w_shreg_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic                       r_ready;
    logic                       w_ready_nxt;
    logic                       r_busy;
    logic                       w_busy_nxt;
    logic [SAMPLES_PER_CLK-1:0] r_window;
    logic [SAMPLES_PER_CLK-1:0] w_cur_win;
    logic [SAMPLES_PER_CLK-1:0] w_out_win;
    logic                       w_xfer;

    assign w_xfer = bus.s_valid && r_ready;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A word is only ever accepted while ready, so a transfer always lands in SHIFT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_xfer) w_state_nxt = SHIFT;
            SHIFT:   if ((r_cnt == CNT_W'(1)) && !w_xfer) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_cur_win   = expand_pair(IDLE_PAIR);
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_shreg_nxt = bus.s_data;
                    w_cnt_nxt   = CNT_W'(PAIRS);
                end
            end
            SHIFT: begin
                w_cur_win = expand_pair(r_shreg[BITS_PER_CLK-1:0]);
                if (w_xfer) begin
                    w_shreg_nxt = bus.s_data;
                    w_cnt_nxt   = CNT_W'(PAIRS);
                end else begin
                    w_shreg_nxt = r_shreg >> BITS_PER_CLK;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
        // Ready is precomputed so it depends only on registered state.
        w_ready_nxt = (w_state_nxt == IDLE) || (w_cnt_nxt == CNT_W'(1));
        w_busy_nxt  = (w_state_nxt == SHIFT);
    end

`ifdef TX_PHASE_SHIFT_EN
    tx_phase_shifter u_phase_shifter (
        .clk       (clk),
        .areset    (areset),
        .i_phase   (phase),
        .i_cur_win (w_cur_win),
        .o_win_c   (w_out_win)
    );
`else
    assign w_out_win = w_cur_win;
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_window <= '0;
        end else begin
            r_shreg  <= w_shreg_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= w_busy_nxt;
            r_window <= w_out_win;
        end
    end

    assign bus.s_ready       = r_ready;
    assign bus.busy          = r_busy;
    assign bus.sample_window = r_window;

endmodule

// File: tb/tb_oversampled_serial_tx.sv
// Directed self-checking bench for oversampled_serial_tx (default build, phase steps under TX_PHASE_SHIFT_EN).
module tb_oversampled_serial_tx;

    logic clk;
    logic areset;
`ifdef TX_PHASE_SHIFT_EN
    logic [1:0] phase;
`endif

    int checks;
    int failures;

    oversampled_serial_tx_if #(.DATA_W(8)) bus ();

    oversampled_serial_tx #(.DATA_W(8), .IDLE_PAIR(2'b01)) dut (
        .clk    (clk),
        .areset (areset),
`ifdef TX_PHASE_SHIFT_EN
        .phase  (phase),
`endif
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] win, input logic bsy, input logic rdy);
        chk({tag, "_win"},   bus.sample_window, win);
        chk({tag, "_busy"},  8'(bus.busy),      8'(bsy));
        chk({tag, "_ready"}, 8'(bus.s_ready),   8'(rdy));
    endtask

    task automatic step(input string tag, input logic [7:0] win, input logic bsy, input logic rdy);
        @(negedge clk);
        chk_all(tag, win, bsy, rdy);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        areset   = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
`ifdef TX_PHASE_SHIFT_EN
        phase = 2'd0;
`endif

        // Reset held across edges, then released between edges.
        @(negedge clk);
        @(negedge clk);
        chk_all("in_reset", 8'h00, 1'b0, 1'b1);
        areset = 1'b0;
        #1;
        chk_all("post_release_noedge", 8'h00, 1'b0, 1'b1);
        step("idle0", 8'h0F, 1'b0, 1'b1);
        step("idle1", 8'h0F, 1'b0, 1'b1);
        step("idle2", 8'h0F, 1'b0, 1'b1);

        // Single word B4: pairs 00,01,11,10.
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hB4;
        step("b4_acc", 8'h0F, 1'b1, 1'b0);
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        step("b4_p0", 8'h00, 1'b1, 1'b0);
        step("b4_p1", 8'h0F, 1'b1, 1'b0);
        step("b4_p2", 8'hFF, 1'b1, 1'b1);
        step("b4_p3", 8'hF0, 1'b0, 1'b1);
        step("b4_idle", 8'h0F, 1'b0, 1'b1);

        // Back-to-back FF then 00 with no idle gap.
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hFF;
        step("bb_acc", 8'h0F, 1'b1, 1'b0);
        bus.s_data  = 8'h00;
        step("bb_ff0", 8'hFF, 1'b1, 1'b0);
        step("bb_ff1", 8'hFF, 1'b1, 1'b0);
        step("bb_ff2", 8'hFF, 1'b1, 1'b1);
        step("bb_ff3", 8'hFF, 1'b1, 1'b0);
        bus.s_valid = 1'b0;
        step("bb_000", 8'h00, 1'b1, 1'b0);
        step("bb_001", 8'h00, 1'b1, 1'b0);
        step("bb_002", 8'h00, 1'b1, 1'b1);
        step("bb_003", 8'h00, 1'b0, 1'b1);
        step("bb_idle", 8'h0F, 1'b0, 1'b1);

        // Asynchronous reset during the second pair of B4.
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hB4;
        step("rst_acc", 8'h0F, 1'b1, 1'b0);
        bus.s_valid = 1'b0;
        step("rst_p0", 8'h00, 1'b1, 1'b0);
        step("rst_p1", 8'h0F, 1'b1, 1'b0);
        areset = 1'b1;
        #1;
        chk_all("rst_async", 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk_all("rst_held", 8'h00, 1'b0, 1'b1);
        areset = 1'b0;
        step("rst_idle0", 8'h0F, 1'b0, 1'b1);
        step("rst_idle1", 8'h0F, 1'b0, 1'b1);
        step("rst_idle2", 8'h0F, 1'b0, 1'b1);
        step("rst_idle3", 8'h0F, 1'b0, 1'b1);

        // Data changing every cycle while busy: only 11 and then 6C are taken.
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        step("chg_acc", 8'h0F, 1'b1, 1'b0);
        bus.s_data  = 8'hAA;
        step("chg_a0", 8'h0F, 1'b1, 1'b0);
        bus.s_data  = 8'h55;
        step("chg_a1", 8'h00, 1'b1, 1'b0);
        bus.s_data  = 8'h33;
        step("chg_a2", 8'h0F, 1'b1, 1'b1);
        bus.s_data  = 8'h6C;
        step("chg_a3", 8'h00, 1'b1, 1'b0);
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h99;
        step("chg_b0", 8'h00, 1'b1, 1'b0);
        step("chg_b1", 8'hFF, 1'b1, 1'b0);
        step("chg_b2", 8'hF0, 1'b1, 1'b1);
        step("chg_b3", 8'h0F, 1'b0, 1'b1);
        step("chg_idle", 8'h0F, 1'b0, 1'b1);

`ifdef TX_PHASE_SHIFT_EN
        phase = 2'd1;
        step("ph1_a", 8'h1E, 1'b0, 1'b1);
        step("ph1_b", 8'h1E, 1'b0, 1'b1);
        phase = 2'd3;
        step("ph3_a", 8'h78, 1'b0, 1'b1);
        step("ph3_b", 8'h78, 1'b0, 1'b1);
        phase = 2'd0;
        step("ph0_a", 8'h0F, 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
